uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one UART transmit line among `NREQ` on-chip requesters (debug console, status reporter, loopback echo, etc.). It arbitrates byte requests round-robin and sequences the bit-period timing. It serializes each granted byte as an 8N1 frame, or 8E1 when parity is enabled. It sits between the requester-side byte producers and the `tx` pad.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `BPS_PARA`, 434, clk cycles per bit (e.g. 50 MHz / 115200); legal 4..8191
- `clk`  in  1  system clock
- `RSTn`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  per-requester "byte pending"; level, held until acked
- `data`  in  NREQ*8  byte of requester i at `data[8i+7:8i]`; stable while `req[i]` high
- `ack`  out  NREQ  one-cycle pulse: byte of requester i captured
- `busy`  out  1  frame in progress
- `cur_id`  out  3  index of requester owning current/last frame
- `tx`  out  1  serial line, idle high

## Operation
- Reset values: `tx`=1, `ack`=0, `busy`=0, `cur_id`=0, state IDLE, bit counter 0, RR pointer `last`=NREQ-1.
- States: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE, no `req`: hold `tx`=1 and `busy`=0.
- IDLE, any `req`: on the same edge:
  - Select the first asserted index searching `last+1, last+2, …` modulo NREQ.
  - Latch its byte into the shift register.
  - Set `cur_id` and `last` to the winner.
  - Drive `ack[winner]`=1 for exactly one cycle, `tx`=0, `busy`=1.
  - Go to START.
- Each bit is held exactly `BPS_PARA` cycles. An internal period counter (13 bits) restarts at 0 on frame start and at every bit boundary. The boundary fires when counter == BPS_PARA-1.
- START → DATA: send 8 bits LSB first; a 3-bit index counts 0..7.
- DATA (bit 7 done) → STOP, or → PARITY if enabled.
- STOP: `tx`=1 for BPS_PARA cycles, then → IDLE with `busy`=0.
- `req` withdrawn before ack: no frame for that requester. `req` changes during a frame are ignored until IDLE.
- Requester must drop or renew `req` the cycle after `ack`. If it is still high, a second byte is sent after the current frame, subject to RR order.
- Async reset mid-frame: `tx` returns to 1 immediately. The partial frame is abandoned, no `ack` is issued, and all state returns to reset values.

## Timing
- `ack`, `tx` start edge and `busy` rise are all registered on the grant edge, i.e. 1 cycle after `req` is sampled in IDLE.
- Frame length: 10·BPS_PARA cycles, or 11·BPS_PARA with parity.
- Back-to-back: after STOP the FSM spends exactly 1 cycle in IDLE. The next start bit begins 10·BPS_PARA+1 cycles after the previous one.
- `busy` falls on the same edge that leaves STOP.
- The `tx` output is registered and glitch-free.

## Configuration
- `UART_ARB_PARITY_EN` defined: a PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits) for BPS_PARA cycles.
- Not defined: there is no PARITY state and the frame is 8N1.

## Structure
- Shared package `uart_pkg`:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP)
  - `UART_DATA_W`=8
  - `UART_CNT_W`=13
  - function computing BPS_PARA from clock and baud
- Sub-module `uart_rr_pick`: combinational round-robin selector (`req`, `last` → `valid`, `winner`). The bit-period counter stays inline.

## Test plan
- Single request: `req`=0001, `data[7:0]`=0x55, BPS_PARA=8 → `ack[0]` pulses 1 cycle after `req`. `tx` = 0,1,0,1,0,1,0,1,0,1, each held 8 cycles, then idle high. `busy` is high 80 cycles.
- Round-robin: all `req`=1111 held, each requester sending a distinct byte → grants in order 0,1,2,3,0. Consecutive start bits are 81 cycles apart at BPS_PARA=8.
- Fairness after skip: `last`=1, `req`=1001 → requester 3 granted before 0.
- Withdraw: `req[2]` pulses high for 1 cycle while busy → no `ack[2]` and no frame for requester 2.
- Reset mid-frame: assert RSTn=0 during DATA bit 3 → `tx`=1, `busy`=0, `ack`=0 immediately. After release, a `req[0]` with 0xA3 produces a full correct frame.
- With `UART_ARB_PARITY_EN`: byte 0x07 → parity bit 1 and an 88-cycle frame at BPS_PARA=8. Byte 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: FSM state encoding, datapath widths, and a helper that derives the
// bit period (clk cycles per bit) from a clock frequency and a baud rate.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_CNT_W  = 13;
  localparam int unsigned UART_ID_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Rounded clk cycles per bit, e.g. uart_bps_para(50_000_000, 115_200) = 434.
  function automatic int unsigned uart_bps_para(input int unsigned clk_hz,
                                                input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req    in  NREQ  pending requests
//   last   in  3     index granted most recently
//   valid  out 1     at least one request pending
//   winner out 3     first pending index after last, searching modulo NREQ
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]      req,
  input  logic [UART_ID_W-1:0] last,
  output logic                 valid,
  output logic [UART_ID_W-1:0] winner
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Scan from the farthest candidate down so the nearest one after last wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % int'(NREQ))]) begin
        valid  = 1'b1;
        winner = UART_ID_W'((int'(last) + k) % int'(NREQ));
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among NREQ byte requesters;
// each granted byte is sent as an 8N1 frame (8E1 with UART_ARB_PARITY_EN).
// Ports:
//   clk, RSTn   clock, asynchronous active-low reset
//   req         per-requester byte pending (level, held until ack)
//   data        byte of requester i at data[8i+7:8i]
//   ack         one-cycle pulse when requester i's byte is captured
//   busy        frame in progress
//   cur_id      requester owning the current/last frame
//   tx          serial line, idle high
// Optional build macro: UART_ARB_PARITY_EN adds an even-parity bit before STOP.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BPS_PARA = 434
) (
  input  logic                        clk,
  input  logic                        RSTn,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*UART_DATA_W-1:0] data,
  output logic [NREQ-1:0]             ack,
  output logic                        busy,
  output logic [UART_ID_W-1:0]        cur_id,
  output logic                        tx
);

  localparam logic [UART_CNT_W-1:0] BIT_END = UART_CNT_W'(BPS_PARA - 1);

  uart_state_e             state_q, state_d;
  logic [UART_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]              bit_q, bit_d;
  logic [UART_DATA_W-1:0]  shift_q, shift_d;
  logic [UART_ID_W-1:0]    last_q, last_d;
  logic [UART_ID_W-1:0]    cur_id_q, cur_id_d;
  logic [NREQ-1:0]         ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    tx_q, tx_d;
`ifdef UART_ARB_PARITY_EN
  logic                    par_q, par_d;
`endif

  logic                    pick_valid;
  logic [UART_ID_W-1:0]    pick_id;
  logic [UART_DATA_W-1:0]  pick_byte;
  logic                    bit_end;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // Byte of the current round-robin winner.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_id == UART_ID_W'(i)) pick_byte = data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  assign bit_end = (cnt_q == BIT_END);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    last_d   = last_q;
    cur_id_d = cur_id_q;
    ack_d    = '0;
    busy_d   = busy_q;
    tx_d     = tx_q;
`ifdef UART_ARB_PARITY_EN
    par_d    = par_q;
`endif

    // Bit-period counter wraps at every bit boundary while a frame runs.
    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + UART_CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        bit_d  = '0;
        if (pick_valid) begin
          state_d  = ST_START;
          shift_d  = pick_byte;
          last_d   = pick_id;
          cur_id_d = pick_id;
          ack_d    = NREQ'(1) << pick_id;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_ARB_PARITY_EN
          par_d    = ^pick_byte;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // LSB is on the line; shift so the next bit sits at [0].
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_ARB_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      last_q   <= UART_ID_W'(NREQ - 1);
      cur_id_q <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
`ifdef UART_ARB_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      cur_id_q <= cur_id_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
`ifdef UART_ARB_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign ack    = ack_q;
  assign busy   = busy_q;
  assign cur_id = cur_id_q;
  assign tx     = tx_q;

endmodule
